// File: rtl/hs_pack_if.sv
// Handshake bundle for hs_pack: narrow beat input side and wide word output side.
interface hs_pack_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DW-1:0]         s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [DW*RATIO-1:0]   m_data;
  logic [RATIO-1:0]      m_keep;
  logic                  m_last;

  // Packer side: consumes beats, produces words.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  // Environment side: drives beats, consumes words.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/hs_pack.sv
// Width-converting packer: gathers RATIO DW-bit beats (LSB lane first) into one
// registered DW*RATIO-bit word, flushing partial words on s_last.
module hs_pack #(
  parameter int unsigned DW    = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic      clk,
  input  logic      rst,
  hs_pack_if.slave  bus
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned WW = DW * RATIO;
  localparam logic [CW-1:0] LastLane = CW'(RATIO - 1);

  logic [WW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [WW-1:0]    m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;

  logic             s_ready;
  logic             accept;
  logic             complete;
  logic [WW-1:0]    merged;
  logic [RATIO-1:0] keep_mask;

  assign s_ready      = ~m_valid_q | bus.m_ready;
  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_keep   = m_keep_q;
  assign bus.m_last   = m_last_q;

  // Beat merge, lane mask and next-state for accumulator and output register.
  always_comb begin
    accept   = bus.s_valid & s_ready;
    complete = accept & ((cnt_q == LastLane) | bus.s_last);

    // Lanes above cnt_q are always zero in acc_q, so unfilled lanes output as 0.
    merged = acc_q;
    merged[cnt_q*DW +: DW] = bus.s_data;

    keep_mask = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      keep_mask[i] = (CW'(i) <= cnt_q);
    end

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;

    if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        acc_d     = '0;
        cnt_d     = '0;
        m_valid_d = 1'b1;
        m_data_d  = merged;
        m_keep_d  = keep_mask;
        m_last_d  = bus.s_last;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

endmodule

// File: tb/tb_hs_pack.sv
// Directed self-checking bench for hs_pack (DW=8, RATIO=4).
module tb_hs_pack;

  localparam int unsigned DW    = 8;
  localparam int unsigned RATIO = 4;

  logic clk;
  logic rst;

  hs_pack_if #(.DW(DW), .RATIO(RATIO)) bus ();

  hs_pack #(.DW(DW), .RATIO(RATIO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Output words observed at handshake edges.
  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];

  always @(posedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      q_data.push_back(bus.m_data);
      q_keep.push_back(bus.m_keep);
      q_last.push_back(bus.m_last);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] data, input logic last);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    bus.s_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("send_timeout", 64'd0, 64'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] data, input logic [3:0] keep,
                             input logic last);
    if (q_data.size() == 0) begin
      check_eq({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_data"}, q_data.pop_front(), data);
      check_eq({tag, "_keep"}, q_keep.pop_front(), keep);
      check_eq({tag, "_last"}, q_last.pop_front(), last);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    bus.s_last  = 1'b1;
    bus.m_ready = 1'b1;

    // Reset held for two cycles with s_valid high.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_m_valid", bus.m_valid, 0);
      check_eq("rst_m_data",  bus.m_data,  0);
      check_eq("rst_m_keep",  bus.m_keep,  0);
      check_eq("rst_m_last",  bus.m_last,  0);
    end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge clk);
    check_eq("post_rst_s_ready", bus.s_ready, 1);
    check_eq("post_rst_m_valid", bus.m_valid, 0);
    @(posedge clk);
    #1;

    // Full word, back to back, s_ready must stay high.
    send(8'h11, 1'b0);
    check_eq("full_s_ready1", bus.s_ready, 1);
    send(8'h22, 1'b0);
    check_eq("full_s_ready2", bus.s_ready, 1);
    send(8'h33, 1'b0);
    check_eq("full_s_ready3", bus.s_ready, 1);
    send(8'h44, 1'b0);
    @(negedge clk);
    check_eq("full_latency_valid", bus.m_valid, 1);
    check_eq("full_latency_data",  bus.m_data,  32'h44332211);
    check_eq("full_s_ready4",      bus.s_ready, 1);
    idle(2);
    expect_word("full", 32'h44332211, 4'hF, 1'b0);
    check_eq("full_count", q_data.size(), 0);

    // Partial flush, then single beat and last-on-full.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    idle(2);
    expect_word("partial", 32'h0000BBAA, 4'h3, 1'b1);
    send(8'h5C, 1'b1);
    idle(2);
    expect_word("single", 32'h0000005C, 4'h1, 1'b1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    idle(2);
    expect_word("last_full", 32'h04030201, 4'hF, 1'b1);
    check_eq("flush_count", q_data.size(), 0);

    // Backpressure: word held with m_ready low, next beats stall.
    bus.m_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_s_ready", bus.s_ready, 0);
      check_eq("bp_m_valid", bus.m_valid, 1);
      check_eq("bp_m_data",  bus.m_data,  32'h44332211);
      check_eq("bp_m_keep",  bus.m_keep,  4'hF);
      check_eq("bp_m_last",  bus.m_last,  0);
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    idle(2);
    expect_word("bp_first",  32'h44332211, 4'hF, 1'b0);
    expect_word("bp_second", 32'h88776655, 4'hF, 1'b0);
    check_eq("bp_count", q_data.size(), 0);

    // Reset mid-packet discards the partial word.
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    idle(3);
    check_eq("rst_mid_count", q_data.size(), 1);
    expect_word("rst_mid", 32'h06050403, 4'hF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hs_pack.md
# hs_pack

Width-converting packer that sits directly downstream of the single-register valid/ready pipeline stage. It accepts DW-bit beats over a valid/ready handshake and packs RATIO consecutive beats into one DW*RATIO-bit word. It also flushes partial words on `s_last` and presents each word on a registered valid/ready master port. It gives the narrow per-beat datapath a wide interface toward the downstream buffer/bus.

## Interface
- `DW`, default 8: width of one input beat.
- `RATIO`, default 4: beats per output word; legal range 2..16.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `s_valid`  in  1: input beat valid.
- `s_ready`  out  1: input beat accepted when `s_valid & s_ready`.
- `s_data`  in  DW: input beat.
- `s_last`  in  1: beat is the last of a packet; qualified by `s_valid`.
- `m_valid`  out  1: output word valid (registered).
- `m_ready`  in  1: downstream accepts the word when `m_valid & m_ready`.
- `m_data`  out  DW*RATIO: packed word (registered).
- `m_keep`  out  RATIO: lane-valid mask, one bit per DW lane (registered).
- `m_last`  out  1: word ends a packet (registered).

## Operation
- **Lane order:** the beat accepted at lane index `cnt` is written to `acc[cnt*DW +: DW]`. The first beat of a word goes to lane 0, the least-significant bits.
- **Lane counter:** `cnt` is `$clog2(RATIO)` bits wide, range 0..RATIO-1. It increments on each accepted non-completing beat and returns to 0 on a completing beat.
- **Completing beat:** an accepted beat with `cnt == RATIO-1` or `s_last == 1`. On that edge:
  - `m_data` <= accumulator contents merged with the current beat in lane `cnt`;
  - `m_keep` <= bits 0..cnt set, others 0;
  - `m_last` <= `s_last`;
  - `m_valid` <= 1;
  - accumulator and `cnt` clear to 0.
- **Unfilled lanes:** lanes above `cnt` in a partial word output as 0.
- **Input ready:** `s_ready = ~m_valid | m_ready`. This is purely combinational from registered `m_valid` and input `m_ready`, with no dependence on `s_valid`, `s_data` or `s_last`.
- **Output drain:** `m_valid` clears on `m_valid & m_ready` unless a completing beat is accepted the same cycle, in which case it stays 1 and the new word loads.
- **Output stability:** while `m_valid & ~m_ready`, `m_data`, `m_keep` and `m_last` hold stable and `s_ready` is 0.
- **Reset values:** `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0; internal `cnt`=0, accumulator=0.
- **Reset mid-packet:** the partial word in the accumulator is discarded and no output is produced for it. A valid but unaccepted output word is also discarded.
- **`s_last` with `cnt == RATIO-1`:** produces a full word, `m_keep` all ones, `m_last`=1.
- **`s_valid` low:** accumulator and `cnt` are unchanged regardless of `s_data` or `s_last`.

## Timing
- Latency from the completing beat accepted at edge N to `m_valid`=1 after edge N is one cycle. Non-completing beats produce no output.
- Throughput with `m_ready` held 1 is one beat per cycle sustained, `s_ready` constantly 1. This gives one word per RATIO cycles.
- The output register is free for a new word in the same cycle it is drained.
- There is no combinational path from `s_*` to `m_*`. The only comb path is `m_ready` -> `s_ready`.
- `m_valid` never drops without a handshake, except on `rst`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `s_valid`=1. Required:
  - all `m_*` outputs are 0 during and after reset;
  - `s_ready`=1 the first cycle after release.
- **Full word:** DW=8, RATIO=4, `m_ready`=1. Beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `s_last`=0. Required:
  - one word one cycle after the 4th beat: `m_data`=0x44332211, `m_keep`=0xF, `m_last`=0;
  - `s_ready` never low.
- **Partial flush:** beats 0xAA then 0xBB with `s_last`=1. Required:
  - `m_data`=0x0000BBAA, `m_keep`=0x3, `m_last`=1;
  - the next word starts at lane 0.
- **Single-beat packet and last-on-full:**
  - beat 0x5C with `s_last`=1 -> `m_data`=0x0000005C, `m_keep`=0x1, `m_last`=1;
  - 4 beats with `s_last` on the 4th -> `m_keep`=0xF, `m_last`=1.
- **Backpressure:** complete word 0x44332211, hold `m_ready`=0 for 3 cycles while `s_valid`=1 with beats 0x55..0x88. Required:
  - `s_ready`=0 for those cycles and `m_*` stable;
  - on raising `m_ready`, the beats are accepted, producing 0x88776655 with no lost or duplicated beat.
- **Reset mid-packet:** accept 0x01, 0x02, then pulse `rst`, then send 0x03, 0x04, 0x05, 0x06. Required: exactly one word, 0x06050403 with `m_keep`=0xF; the pre-reset beats never appear.
